// File: rtl/sal_sched_pkg.sv
// Shared types for the inter-bank command arbiter: DRAM command encoding and arbitration classes.
package sal_sched_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } sal_cmd_t;

    // Listed in descending priority; RD and WR share the CAS class.
    typedef enum logic [1:0] {
        ClsRef = 2'd0,
        ClsCas = 2'd1,
        ClsAct = 2'd2,
        ClsPre = 2'd3
    } sal_cls_t;

    localparam int unsigned NUM_CLASSES = 4;

endpackage

// File: rtl/sal_sched_arbiter_if.sv
// Bank-scheduler side of the arbiter: per-bank req/gnt and fields, plus the registered command.
interface sal_sched_arbiter_if
    import sal_sched_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned RA_W      = 16,
    parameter int unsigned CA_W      = 10,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned LEN_W     = 4
) ();
    localparam int unsigned BA_W = $clog2(NUM_BANKS);

    logic [NUM_BANKS-1:0]       act_req, rd_req, wr_req, pre_req, ref_req;
    logic [NUM_BANKS-1:0]       act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [NUM_BANKS*RA_W-1:0]  ra;
    logic [NUM_BANKS*CA_W-1:0]  ca;
    logic [NUM_BANKS*ID_W-1:0]  id;
    logic [NUM_BANKS*LEN_W-1:0] len;

    logic                       cmd_valid;
    sal_cmd_t                   cmd_type;
    logic [BA_W-1:0]            cmd_ba;
    logic [RA_W-1:0]            cmd_ra;
    logic [CA_W-1:0]            cmd_ca;
    logic [ID_W-1:0]            cmd_id;
    logic [LEN_W-1:0]           cmd_len;

    modport slave (
        input  act_req, rd_req, wr_req, pre_req, ref_req, ra, ca, id, len,
        output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
        output cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len
    );

    modport master (
        output act_req, rd_req, wr_req, pre_req, ref_req, ra, ca, id, len,
        input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
        input  cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len
    );

endinterface

// File: rtl/sal_rr_picker.sv
// One-hot picker over N requesters: search from ptr with wrap (round-robin) or from 0 (fixed).
module sal_rr_picker #(
    parameter int unsigned N        = 4,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 valid
);
    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] start, idx;

    assign start = (ARB_MODE == 1) ? '0 : ptr;

    // N is a power of two, so the index add wraps naturally.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = start + IW'(i);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sal_sched_arbiter.sv
// Inter-bank DRAM command arbiter: one grant per cycle under class priority and inter-bank
// timing (tRRD/tCCD/tWTR/tRTW), winning command registered for the issue stage.
module sal_sched_arbiter
    import sal_sched_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned RA_W      = 16,
    parameter int unsigned CA_W      = 10,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned ARB_MODE  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   t_rrd_m1,
    input  logic [CNT_W-1:0]   t_ccd_m1,
    input  logic [CNT_W-1:0]   t_wtr_m1,
    input  logic [CNT_W-1:0]   t_rtw_m1,
    sal_sched_arbiter_if.slave bus
);
    localparam int unsigned BA_W = $clog2(NUM_BANKS);

    logic [CNT_W-1:0]       rrd_cnt_q, ccd_cnt_q, wtr_cnt_q, rtw_cnt_q;
    logic [BA_W-1:0]        rr_ptr_q, gnt_idx;
    logic                   act_ok, rd_ok, wr_ok, any_gnt;
    logic [NUM_BANKS-1:0]   ref_m, rd_m, wr_m, cas_m, act_m, pre_m;
    logic [NUM_BANKS-1:0]   ref_oh, cas_oh, act_oh, pre_oh, sel_oh;
    logic [NUM_CLASSES-1:0] cls_valid;
    sal_cls_t               cls;
    sal_cmd_t               cmd_d;

    logic                   cmd_valid_q;
    sal_cmd_t               cmd_type_q;
    logic [BA_W-1:0]        cmd_ba_q;
    logic [RA_W-1:0]        cmd_ra_q;
    logic [CA_W-1:0]        cmd_ca_q;
    logic [ID_W-1:0]        cmd_id_q;
    logic [LEN_W-1:0]       cmd_len_q;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    assign act_ok = (rrd_cnt_q == '0);
    assign rd_ok  = (ccd_cnt_q == '0) && (wtr_cnt_q == '0);
    assign wr_ok  = (ccd_cnt_q == '0) && (rtw_cnt_q == '0);

    // Eligibility first, then keep only each bank's highest surviving class (RD beats WR).
    assign ref_m = bus.ref_req;
    assign rd_m  = bus.rd_req & {NUM_BANKS{rd_ok}} & ~ref_m;
    assign wr_m  = bus.wr_req & {NUM_BANKS{wr_ok}} & ~ref_m & ~rd_m;
    assign cas_m = rd_m | wr_m;
    assign act_m = bus.act_req & {NUM_BANKS{act_ok}} & ~ref_m & ~cas_m;
    assign pre_m = bus.pre_req & ~ref_m & ~cas_m & ~act_m;

    sal_rr_picker #(.N(NUM_BANKS), .ARB_MODE(ARB_MODE)) u_ref_pick (
        .req(ref_m), .ptr(rr_ptr_q), .gnt(ref_oh), .valid(cls_valid[ClsRef])
    );
    sal_rr_picker #(.N(NUM_BANKS), .ARB_MODE(ARB_MODE)) u_cas_pick (
        .req(cas_m), .ptr(rr_ptr_q), .gnt(cas_oh), .valid(cls_valid[ClsCas])
    );
    sal_rr_picker #(.N(NUM_BANKS), .ARB_MODE(ARB_MODE)) u_act_pick (
        .req(act_m), .ptr(rr_ptr_q), .gnt(act_oh), .valid(cls_valid[ClsAct])
    );
    sal_rr_picker #(.N(NUM_BANKS), .ARB_MODE(ARB_MODE)) u_pre_pick (
        .req(pre_m), .ptr(rr_ptr_q), .gnt(pre_oh), .valid(cls_valid[ClsPre])
    );

    always_comb begin
        cls    = ClsPre;
        sel_oh = pre_oh;
        if (cls_valid[ClsRef]) begin
            cls    = ClsRef;
            sel_oh = ref_oh;
        end else if (cls_valid[ClsCas]) begin
            cls    = ClsCas;
            sel_oh = cas_oh;
        end else if (cls_valid[ClsAct]) begin
            cls    = ClsAct;
            sel_oh = act_oh;
        end
    end

    assign any_gnt = rst_n && (|cls_valid);

    always_comb begin
        cmd_d = CMD_NOP;
        if (any_gnt) begin
            unique case (cls)
                ClsRef: cmd_d = CMD_REF;
                ClsCas: cmd_d = (|(sel_oh & rd_m)) ? CMD_RD : CMD_WR;
                ClsAct: cmd_d = CMD_ACT;
                ClsPre: cmd_d = CMD_PRE;
            endcase
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (sel_oh[b]) gnt_idx = BA_W'(b);
        end
    end

    assign bus.ref_gnt = (cmd_d == CMD_REF) ? sel_oh : '0;
    assign bus.rd_gnt  = (cmd_d == CMD_RD)  ? sel_oh : '0;
    assign bus.wr_gnt  = (cmd_d == CMD_WR)  ? sel_oh : '0;
    assign bus.act_gnt = (cmd_d == CMD_ACT) ? sel_oh : '0;
    assign bus.pre_gnt = (cmd_d == CMD_PRE) ? sel_oh : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rrd_cnt_q   <= '0;
            ccd_cnt_q   <= '0;
            wtr_cnt_q   <= '0;
            rtw_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_NOP;
            cmd_ba_q    <= '0;
            cmd_ra_q    <= '0;
            cmd_ca_q    <= '0;
            cmd_id_q    <= '0;
            cmd_len_q   <= '0;
        end else begin
            rrd_cnt_q <= (cmd_d == CMD_ACT) ? t_rrd_m1 : sat_dec(rrd_cnt_q);
            ccd_cnt_q <= (cmd_d == CMD_RD || cmd_d == CMD_WR) ? t_ccd_m1 : sat_dec(ccd_cnt_q);
            wtr_cnt_q <= (cmd_d == CMD_WR) ? t_wtr_m1 : sat_dec(wtr_cnt_q);
            rtw_cnt_q <= (cmd_d == CMD_RD) ? t_rtw_m1 : sat_dec(rtw_cnt_q);
            cmd_valid_q <= any_gnt;
            cmd_type_q  <= cmd_d;
            if (any_gnt) begin
                rr_ptr_q  <= gnt_idx + BA_W'(1);
                cmd_ba_q  <= gnt_idx;
                cmd_ra_q  <= bus.ra[gnt_idx*RA_W +: RA_W];
                cmd_ca_q  <= bus.ca[gnt_idx*CA_W +: CA_W];
                cmd_id_q  <= bus.id[gnt_idx*ID_W +: ID_W];
                cmd_len_q <= bus.len[gnt_idx*LEN_W +: LEN_W];
            end
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_type  = cmd_type_q;
    assign bus.cmd_ba    = cmd_ba_q;
    assign bus.cmd_ra    = cmd_ra_q;
    assign bus.cmd_ca    = cmd_ca_q;
    assign bus.cmd_id    = cmd_id_q;
    assign bus.cmd_len   = cmd_len_q;

endmodule
